snake_dir_ctrl: RTL
===================

# snake_dir_ctrl

Parametrised direction controller for the snake game: synchronises and debounces the four active-low direction buttons and rejects 180° reversals. It also queues accepted presses in a small FIFO and applies exactly one queued direction per game-step tick. It replaces the direct button-to-`move_direction` mapping inside `snake`. Its output feeds the snake head-update logic, with the same 2-bit direction encoding.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required before a button state change is accepted; ≥1.
- `QUEUE_DEPTH`, 2: pending-direction FIFO depth; power of two, ≥2.
- `RESET_DIR`, 2: `move_direction` value after reset (2 = right).
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn`  in  4  raw buttons, active-low, asynchronous: bit0 = left (btn1), bit1 = up (btn2), bit2 = right (btn3), bit3 = down (btn4).
- `tick`  in  1  game-step strobe, one `clk` cycle wide, synchronous.
- `move_direction`  out  2  current direction: 0 left, 1 up, 2 right, 3 down.
- `dir_change`  out  1  one-cycle pulse when `move_direction` takes a new value.
- `press_drop`  out  1  one-cycle pulse when a debounced press is discarded (reverse, duplicate or queue full).
- `queue_count`  out  clog2(QUEUE_DEPTH+1)  number of pending directions.

## Operation
- Reset (`reset`=0, asynchronous): synchronisers and debounced state = 1 (released); debounce counters = 0; queue empty; `move_direction`=RESET_DIR; `dir_change`=0, `press_drop`=0, `queue_count`=0.
- Per button:
  - 2-flop synchroniser.
  - Debounce counter increments while the synchronised value differs from the debounced state, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES−1 and the values still differ, the debounced state flips and the counter clears.
- Press event = debounced 1→0, registered one cycle. A release generates no event.
- Simultaneous press events in one cycle: the lowest bit index wins (left > up > right > down). The others are ignored and raise no `press_drop`.
- Reference direction R = newest queue entry if `queue_count`>0, else `move_direction`.
- An event with direction D is dropped (`press_drop`=1) when any of these holds:
  - D == R (duplicate);
  - D == R ^ 2 (reversal);
  - the queue is full and no pop occurs in the same cycle.
- Otherwise D is pushed.
- On `tick`=1 with the queue non-empty: pop the oldest entry into `move_direction`. `dir_change`=1 if the popped value differs from the old `move_direction`. It always differs, given the enqueue rules.
- On `tick`=1 with the queue empty: no change, no pulse.
- Same-cycle push and pop:
  - Both take effect and `queue_count` is unchanged.
  - R is evaluated before the pop.
  - A push into an empty queue is not poppable in that same cycle; it becomes visible at the next tick.
- `reset` mid-operation discards queued entries and in-progress debounce counts immediately.

## Timing
- Raw `btn` bit held low continuously from before edge k: debounced state flips at edge k+1+DEBOUNCE_CYCLES. The press event registers and the push occurs at edge k+2+DEBOUNCE_CYCLES. `queue_count` increments at that edge.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- Pop: `move_direction`, `dir_change` and `queue_count` update on the edge that samples `tick`=1. `dir_change` deasserts the next edge.
- `press_drop` is asserted for exactly the cycle after the edge at which the event was evaluated.
- Queue pointers wrap modulo QUEUE_DEPTH. `queue_count` saturates by construction at QUEUE_DEPTH and never exceeds it.

## Test plan
Use DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, RESET_DIR=2.

1. Reset: assert `reset`=0 with all `btn`=1, then release. Require `move_direction`=2, `queue_count`=0, no pulses; a tick produces no change.
2. Down then tick: hold `btn`[3]=0 for 10 cycles. Require `queue_count`=1 exactly 6 edges after the first low sample. Then tick: `move_direction`=3 and a single-cycle `dir_change`.
3. Reversal and duplicate: with `move_direction`=2, press left (`btn`[0]). Require `press_drop`=1 and `queue_count`=0. Then press right: `press_drop`=1.
4. Queueing: with direction 2, press up, then left, before any tick. Require `queue_count`=2. First tick → 1, second tick → 0. A third press while full is dropped.
5. Debounce: pulse `btn`[1] low for 3 cycles. Require no event. Simultaneous down+up presses: up is accepted, down is ignored with no drop.
6. Edge cases:
   - Tick and push in the same cycle with the queue full: count stays 2 and order is preserved.
   - `reset` low with 2 entries queued: the queue empties and `move_direction`=2 immediately.

Source files
------------

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
// Direction controller for the snake game. It synchronises and debounces the four
// active-low direction buttons, rejects duplicate and 180-degree reversal presses,
// and queues accepted presses. One queued direction is applied per game-step tick.
// Direction encoding: 0 left, 1 up, 2 right, 3 down.
// The button index equals the direction code: bit0 left, bit1 up, bit2 right, bit3 down.
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int QUEUE_DEPTH     = 2,
    parameter int RESET_DIR       = 2,
    localparam int CW             = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    btn,
    input  logic          tick,
    output logic [1:0]    move_direction,
    output logic          dir_change,
    output logic          press_drop,
    output logic [CW-1:0] queue_count
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(QUEUE_DEPTH);
    localparam logic [1:0]    DIR_RESET  = 2'(RESET_DIR);

    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;
    logic [3:0]          r_deb;
    logic [3:0][DW-1:0]  r_cnt;
    logic [3:0]          r_ev;

    logic [1:0]          r_q [QUEUE_DEPTH];
    logic [PW-1:0]       r_wr;
    logic [PW-1:0]       r_rd;

    logic [3:0]          w_fall;
    logic                w_ev_valid;
    logic [1:0]          w_ev_dir;
    logic [PW-1:0]       w_newest;
    logic [1:0]          w_ref;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // Two-flop synchroniser on the raw asynchronous buttons (idle = released = 1).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // A debounced bit falls from 1 to 0 on the edge where its counter expires while still differing.
    always_comb begin
        w_fall = '0;
        for (int i = 0; i < 4; i++) begin
            w_fall[i] = r_deb[i] && !r_sync2[i] && (r_cnt[i] == DEB_LAST);
        end
    end

    // Per-button debounce counters; the press event is the registered falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deb <= 4'hF;
            r_cnt <= '0;
            r_ev  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] == DEB_LAST) begin
                        r_deb[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
            r_ev <= w_fall;
        end
    end

    // Pick one event (lowest index wins) and decide push/drop against the reference direction,
    // which is the newest queued entry, or the live direction when the queue is empty.
    always_comb begin
        w_ev_valid = |r_ev;
        w_ev_dir   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_ev[i]) begin
                w_ev_dir = 2'(i);
            end
        end
        w_newest = r_wr - 1'b1;
        w_ref    = (queue_count != '0) ? r_q[w_newest] : move_direction;
        // Pop only sees entries present before this edge, so a same-cycle push into an empty queue waits.
        w_pop    = tick && (queue_count != '0);
        w_push   = w_ev_valid && (w_ev_dir != w_ref) && (w_ev_dir != (w_ref ^ 2'b10))
                   && ((queue_count != COUNT_FULL) || w_pop);
        w_drop   = w_ev_valid && !w_push;
    end

    // Pending-direction FIFO, applied direction and the two status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q[i] <= 2'd0;
            end
            r_wr           <= '0;
            r_rd           <= '0;
            queue_count    <= '0;
            move_direction <= DIR_RESET;
            dir_change     <= 1'b0;
            press_drop     <= 1'b0;
        end else begin
            if (w_push) begin
                r_q[r_wr] <= w_ev_dir;
                r_wr      <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd           <= r_rd + 1'b1;
                move_direction <= r_q[r_rd];
            end
            case ({w_push, w_pop})
                2'b10:   queue_count <= queue_count + 1'b1;
                2'b01:   queue_count <= queue_count - 1'b1;
                default: queue_count <= queue_count;
            endcase
            dir_change <= w_pop && (r_q[r_rd] != move_direction);
            press_drop <= w_drop;
        end
    end

endmodule
